// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if
// Client-side bundle for the framebuffer arbiter. It carries the VGA scan-out
// read port and the CPU posted-write port.
//   rd_req / rd_addr   : VGA read request and address (held until accepted)
//   rd_ready           : request accepted this cycle when high with rd_req
//   rd_valid / rd_data : one-cycle read-data strobe and data
//   wr_en / wr_addr / wr_data : CPU write strobe, address and data
//   wr_full            : posted-write FIFO full; a write now is dropped
// Modports: master = the VGA/CPU clients, slave = the arbiter.
interface fb_port_arbiter_if;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic        rd_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_full;

    modport master (
        output rd_req, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_ready, rd_valid, rd_data, wr_full
    );

    modport slave (
        input  rd_req, rd_addr, wr_en, wr_addr, wr_data,
        output rd_ready, rd_valid, rd_data, wr_full
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares the single-port 4096x8 framebuffer RAM between the VGA reader and
// the CPU writer. Reads have priority; CPU writes are posted into a small
// FIFO. After MAX_RD_STREAK back-to-back reads with writes pending, one read
// slot is given to the oldest posted write so the FIFO still drains.
// Ports:
//   clk50, rst_n   : 50 MHz clock, asynchronous active-low reset
//   bus (slave)    : VGA read port and CPU write port, see fb_port_arbiter_if
//   ram_addr, ram_wdata, ram_we : registered RAM command
//   ram_rdata      : RAM read data (one-cycle latency, unregistered q)
//   drop_count     : saturating count of writes dropped while full
// Build option: define FB_ARB_DROP_CNT_EN to build the drop counter;
// otherwise drop_count is constant zero.
module fb_port_arbiter #(
    parameter int DEPTH         = 4,
    parameter int MAX_RD_STREAK = 8
) (
    input  logic             clk50,
    input  logic             rst_n,
    fb_port_arbiter_if.slave bus,
    output logic [11:0]      ram_addr,
    output logic [7:0]       ram_wdata,
    output logic             ram_we,
    input  logic [7:0]       ram_rdata,
    output logic [7:0]       drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [7:0]       STREAK_MAX = 8'(MAX_RD_STREAK);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE,
        GNT_FORCE
    } gnt_e;

    logic [11:0]      fifo_addr [DEPTH];
    logic [7:0]       fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [7:0]       streak;
    logic [7:0]       streak_next;
    logic             wr_full_q;
    logic             rd_issue_q;
    logic             rd_valid_q;

    logic fifo_nempty;
    logic force_wr;
    logic push;
    logic pop;
    gnt_e gnt;

    assign fifo_nempty = (count != '0);
    assign force_wr    = (streak == STREAK_MAX) && fifo_nempty;
    // The full flag is registered, so a write arriving while full is dropped
    // even if this cycle also pops an entry.
    assign push        = bus.wr_en && !wr_full_q;
    assign pop         = (gnt == GNT_FORCE) || (gnt == GNT_WRITE);

    assign bus.rd_ready = !force_wr;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = ram_rdata;
    assign bus.wr_full  = wr_full_q;

    always_comb begin
        gnt = GNT_IDLE;
        if (force_wr) begin
            gnt = GNT_FORCE;
        end else if (bus.rd_req) begin
            gnt = GNT_READ;
        end else if (fifo_nempty) begin
            gnt = GNT_WRITE;
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // Only reads made while a write is waiting count toward the streak.
    always_comb begin
        streak_next = streak;
        case (gnt)
            GNT_FORCE, GNT_WRITE: streak_next = 8'd0;
            GNT_READ:             streak_next = fifo_nempty ? streak + 8'd1 : 8'd0;
            default:              streak_next = streak;
        endcase
    end

    // Entries need no reset: the pointers and count define what is valid.
    always_ff @(posedge clk50) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            streak     <= 8'd0;
            wr_full_q  <= 1'b0;
            rd_issue_q <= 1'b0;
            rd_valid_q <= 1'b0;
            ram_addr   <= 12'd0;
            ram_wdata  <= 8'd0;
            ram_we     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            streak     <= streak_next;
            wr_full_q  <= (count_next == CNT_FULL);
            // Address goes out the cycle after acceptance, data returns one
            // cycle later from the RAM.
            rd_issue_q <= (gnt == GNT_READ);
            rd_valid_q <= rd_issue_q;
            case (gnt)
                GNT_FORCE, GNT_WRITE: begin
                    ram_addr  <= fifo_addr[rd_ptr];
                    ram_wdata <= fifo_data[rd_ptr];
                    ram_we    <= 1'b1;
                end
                GNT_READ: begin
                    ram_addr <= bus.rd_addr;
                    ram_we   <= 1'b0;
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef FB_ARB_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_q;

    assign drop = bus.wr_en && wr_full_q;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
// Directed bench for fb_port_arbiter. A queue-based model of the arbitration
// rules predicts every output each cycle; directed scenarios add literal
// expectations for reset, single read, idle write, starvation guard,
// full/drop, push+pop with pointer wrap and reset mid-operation.
module tb_fb_port_arbiter;
    localparam int DEPTH         = 4;
    localparam int MAX_RD_STREAK = 8;

    logic        clk50;
    logic        rst_n;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [7:0]  drop_count;

    fb_port_arbiter_if bus();

    fb_port_arbiter #(
        .DEPTH         (DEPTH),
        .MAX_RD_STREAK (MAX_RD_STREAK)
    ) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .bus        (bus),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .drop_count (drop_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] preload(input int i);
        return (i == 12'h0A5) ? 8'h3C : 8'((i * 7) + 3);
    endfunction

    initial begin
        clk50 = 1'b0;
        forever #10 clk50 = ~clk50;
    end

    // Synchronous single-port RAM, one-cycle read latency.
    logic [7:0] ram_mem [4096];
    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = preload(i);
        ram_rdata = 8'h00;
        forever begin
            @(posedge clk50);
            ram_rdata = ram_mem[ram_addr];
            if (ram_we) ram_mem[ram_addr] = ram_wdata;
        end
    end

    // Reference model: posted-write queue, read streak, memory image.
    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         m_q[$];
    wr_t         m_head;
    int          m_streak = 0;
    int          m_drops  = 0;
    logic [7:0]  m_mem [4096];
    bit          m_stage  = 0;
    logic [7:0]  m_stage_d = 8'h00;
    bit          m_ne;
    bit          m_push;
    logic        exp_rd_valid  = 1'b0;
    logic [7:0]  exp_rd_data   = 8'h00;
    logic        exp_ram_we    = 1'b0;
    logic [11:0] exp_ram_addr  = 12'h000;
    logic [7:0]  exp_ram_wdata = 8'h00;
    logic        exp_wr_full   = 1'b0;

    initial begin
        for (int i = 0; i < 4096; i++) m_mem[i] = preload(i);
        forever begin
            @(posedge clk50 or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_streak      = 0;
                m_drops       = 0;
                m_stage       = 0;
                exp_rd_valid  = 1'b0;
                exp_ram_we    = 1'b0;
                exp_ram_addr  = 12'h000;
                exp_ram_wdata = 8'h00;
                exp_wr_full   = 1'b0;
            end else begin
                m_ne   = (m_q.size() != 0);
                m_push = bus.wr_en && (m_q.size() != DEPTH);
                if (bus.wr_en && (m_q.size() == DEPTH) && (m_drops < 255)) m_drops++;
                exp_rd_valid = m_stage;
                exp_rd_data  = m_stage_d;
                m_stage      = 0;
                if ((m_streak == MAX_RD_STREAK) && m_ne) begin
                    m_head        = m_q.pop_front();
                    exp_ram_we    = 1'b1;
                    exp_ram_addr  = m_head.a;
                    exp_ram_wdata = m_head.d;
                    m_mem[m_head.a] = m_head.d;
                    m_streak      = 0;
                end else if (bus.rd_req) begin
                    exp_ram_we   = 1'b0;
                    exp_ram_addr = bus.rd_addr;
                    m_stage      = 1;
                    m_stage_d    = m_mem[bus.rd_addr];
                    m_streak     = m_ne ? m_streak + 1 : 0;
                end else if (m_ne) begin
                    m_head        = m_q.pop_front();
                    exp_ram_we    = 1'b1;
                    exp_ram_addr  = m_head.a;
                    exp_ram_wdata = m_head.d;
                    m_mem[m_head.a] = m_head.d;
                    m_streak      = 0;
                end else begin
                    exp_ram_we = 1'b0;
                end
                if (m_push) m_q.push_back({bus.wr_addr, bus.wr_data});
                exp_wr_full = (m_q.size() == DEPTH);
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk50);
            check("rd_ready", 32'(bus.rd_ready),
                  32'(!((m_streak == MAX_RD_STREAK) && (m_q.size() != 0))));
            check("rd_valid", 32'(bus.rd_valid), 32'(exp_rd_valid));
            if (exp_rd_valid) check("rd_data", 32'(bus.rd_data), 32'(exp_rd_data));
            check("wr_full", 32'(bus.wr_full), 32'(exp_wr_full));
            check("ram_we", 32'(ram_we), 32'(exp_ram_we));
            check("ram_addr", 32'(ram_addr), 32'(exp_ram_addr));
            if (exp_ram_we) check("ram_wdata", 32'(ram_wdata), 32'(exp_ram_wdata));
`ifdef FB_ARB_DROP_CNT_EN
            check("drop_count", 32'(drop_count), 32'(m_drops));
`else
            check("drop_count", 32'(drop_count), 32'h0);
`endif
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic rq, input logic [11:0] ra,
                         input logic we, input logic [11:0] wa, input logic [7:0] wd);
        @(negedge clk50);
        bus.rd_req  = rq;
        bus.rd_addr = ra;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
    endtask

    logic [11:0] seen[$];
    int          grants;
    int          nwr;

    initial begin
        rst_n       = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = 12'h000;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 12'h000;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk50);
        #5 rst_n = 1'b1;

        // Reset state
        idle(1);
        check("rst_rd_ready", 32'(bus.rd_ready), 32'h1);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_wr_full", 32'(bus.wr_full), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);

        // Single read of preloaded 0x0A5
        drive(1'b1, 12'h0A5, 1'b0, 12'h000, 8'h00);
        idle(1);
        check("rd_addr_c1", 32'(ram_addr), 32'h0A5);
        check("rd_valid_c1", 32'(bus.rd_valid), 32'h0);
        idle(1);
        check("rd_valid_c2", 32'(bus.rd_valid), 32'h1);
        check("rd_data_c2", 32'(bus.rd_data), 32'h3C);
        idle(1);
        check("rd_valid_c3", 32'(bus.rd_valid), 32'h0);

        // Idle write, then read it back
        drive(1'b0, 12'h000, 1'b1, 12'h123, 8'h7E);
        idle(1);
        check("wr_we_c1", 32'(ram_we), 32'h0);
        idle(1);
        check("wr_we_c2", 32'(ram_we), 32'h1);
        check("wr_addr_c2", 32'(ram_addr), 32'h123);
        check("wr_data_c2", 32'(ram_wdata), 32'h7E);
        idle(1);
        check("wr_we_c3", 32'(ram_we), 32'h0);
        drive(1'b1, 12'h123, 1'b0, 12'h000, 8'h00);
        idle(2);
        check("rbw_valid", 32'(bus.rd_valid), 32'h1);
        check("rbw_data", 32'(bus.rd_data), 32'h7E);
        idle(2);

        // Starvation guard: continuous reads, one pending write
        drive(1'b1, 12'h010, 1'b1, 12'h200, 8'h55);
        grants = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 12'h011 + 12'(i), 1'b0, 12'h000, 8'h00);
            if (!bus.rd_ready) break;
            grants++;
        end
        check("streak_grants", 32'(grants), 32'd8);
        drive(1'b1, 12'h040, 1'b0, 12'h000, 8'h00);
        check("forced_we", 32'(ram_we), 32'h1);
        check("forced_addr", 32'(ram_addr), 32'h200);
        check("forced_data", 32'(ram_wdata), 32'h55);
        check("resume_rd_ready", 32'(bus.rd_ready), 32'h1);
        drive(1'b1, 12'h041, 1'b0, 12'h000, 8'h00);
        idle(3);

        // Full/drop: six pushes under saturated reads
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 12'h300 + 12'(i), 1'b1, 12'h400 + 12'(i), 8'hA0 + 8'(i));
            check("fill_wr_full", 32'(bus.wr_full), (i >= 4) ? 32'h1 : 32'h0);
        end
        seen.delete();
        for (int j = 0; j < 45; j++) begin
            drive(1'b1, 12'h310 + 12'(j), 1'b0, 12'h000, 8'h00);
`ifdef FB_ARB_DROP_CNT_EN
            if (j == 0) check("drops", 32'(drop_count), 32'd2);
`else
            if (j == 0) check("drops", 32'(drop_count), 32'd0);
`endif
            if (ram_we) seen.push_back(ram_addr);
        end
        check("drain_count", 32'(seen.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < seen.size()) check("drain_order", 32'(seen[k]), 32'h400 + 32'(k));
        end
        idle(3);

        // Push+pop at count 3, then ten pairs through the wrapping FIFO
        for (int i = 0; i < 3; i++) drive(1'b1, 12'h500 + 12'(i), 1'b1, 12'h600 + 12'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 12'h000, 1'b1, 12'h610 + 12'(i), 8'h20 + 8'(i));
            check("pair_wr_full", 32'(bus.wr_full), 32'h0);
        end
        seen.delete();
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
            if ((j >= 1) && ram_we) seen.push_back(ram_addr);
        end
        check("pair_left", 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < seen.size()) check("wrap_order", 32'(seen[k]), 32'h617 + 32'(k));
        end
        idle(2);

        // Reset mid-operation: two entries queued, read accepted, then reset
        drive(1'b1, 12'h700, 1'b1, 12'h800, 8'hAA);
        drive(1'b1, 12'h701, 1'b1, 12'h801, 8'hBB);
        drive(1'b1, 12'h702, 1'b0, 12'h000, 8'h00);
        drive(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
        #5 rst_n = 1'b0;
        idle(2);
        #5 rst_n = 1'b1;
        nwr = 0;
        for (int j = 0; j < 10; j++) begin
            idle(1);
            if (ram_we || bus.rd_valid || bus.wr_full) nwr++;
        end
        check("post_rst_activity", 32'(nwr), 32'd0);
        check("post_rst_rd_ready", 32'(bus.rd_ready), 32'h1);

        // Read one of the discarded addresses: RAM must still hold preload.
        drive(1'b1, 12'h800, 1'b0, 12'h000, 8'h00);
        idle(2);
        check("discarded_valid", 32'(bus.rd_valid), 32'h1);
        check("discarded_data", 32'(bus.rd_data), 32'(preload(12'h800)));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
